// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
// Contents:
//   - opcode constants for the instructions the hazard logic has to know about
//   - bit positions of the opcode/rs/rt fields in a 32-bit instruction word
//   - REG_ZERO, the hard-wired zero register, which never carries a dependency
//   - pipe_state_t, the hazard controller's state (RUN / STALL / FREEZE)
//   - op_uses_rt(), which tells whether an instruction reads rt as a source
package mips_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } pipe_state_t;

  // Only R-type, the two compare branches and stores read rt; for every other
  // format rt is a destination or an immediate-form field and must not stall.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline stall/flush statistics.
// Ports:
//   clk   - clock
//   clr   - synchronous clear, wins over inc
//   inc   - count one event at this edge
//   count - current value, holds at all-ones once reached
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall/flush controller for the 5-stage MIPS pipeline.
// Covers the hazards the EX forwarding network cannot: load-use, and operands
// of branches resolved in ID. Also freezes the pipe on data-memory wait and
// flushes IF/ID on taken branches and jumps.
//
// Handshake/control semantics: all pipeline controls are Mealy outputs of the
// current-cycle inputs (zero latency). dmem_busy has top priority and freezes
// every register; a hazard holds PC and IF/ID and sends a bubble into ID/EX
// while the older stages drain; a taken branch or jump loads a NOP into IF/ID.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   id_instr            - instruction in ID (opcode/rs/rt decoded here)
//   id_branch           - ID holds beq/bne
//   id_branch_taken     - ID branch resolved taken (meaningful with id_branch)
//   id_jump             - ID holds j/jal/jr
//   ex_mem_read         - EX holds a load
//   ex_reg_write        - EX writes the register file
//   ex_write_reg        - EX destination register
//   mem_mem_read        - MEM holds a load
//   mem_write_reg       - MEM destination register
//   dmem_busy           - data memory wait request
//   pc_write_en         - PC update enable
//   ifid_write_en       - IF/ID enable
//   ifid_flush          - IF/ID loads a NOP
//   idex_bubble         - ID/EX loads zeros
//   exmem_write_en      - EX/MEM enable
//   memwb_write_en      - MEM/WB enable
//   stall_cycles        - saturating count of STALL cycles
//   flush_cycles        - saturating count of flush cycles
//   stall_timeout       - sticky: MAX_STALL consecutive non-RUN cycles seen
//   fsm_state           - debug view of the registered state
module hazard_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_write_reg,
  input  logic             dmem_busy,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_write_en,
  output logic             memwb_write_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
  output logic             stall_timeout,
  output logic [1:0]       fsm_state
);

  localparam int              RL_W   = $clog2(MAX_STALL + 1);
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       unused_instr_bits;

  assign opcode  = id_instr[OPC_MSB:OPC_LSB];
  assign rs      = id_instr[RS_MSB:RS_LSB];
  assign rt      = id_instr[RT_MSB:RT_LSB];
  assign uses_rt = op_uses_rt(opcode);

  // rd/shamt/funct/immediate do not affect hazard detection.
  assign unused_instr_bits = ^id_instr[15:0];

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic load_use;
  logic br_ex;
  logic br_mem;
  logic hazard;
  logic flush_req;

  assign load_use = ex_mem_read && (ex_write_reg != REG_ZERO) &&
                    ((ex_write_reg == rs) || (uses_rt && (ex_write_reg == rt)));

  // A branch compares in ID, so any EX producer (ALU or load) is too late to
  // forward; a load still in MEM is too late as well, giving load->branch two
  // stall cycles in total.
  assign br_ex  = id_branch && ex_reg_write && (ex_write_reg != REG_ZERO) &&
                  ((ex_write_reg == rs) || (ex_write_reg == rt));
  assign br_mem = id_branch && mem_mem_read && (mem_write_reg != REG_ZERO) &&
                  ((mem_write_reg == rs) || (mem_write_reg == rt));

  assign hazard    = load_use || br_ex || br_mem;
  assign flush_req = (id_branch && id_branch_taken) || id_jump;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  pipe_state_t state;
  pipe_state_t next_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = ST_RUN;
    if (dmem_busy) begin
      next_state = ST_FREEZE;
    end else if (hazard) begin
      next_state = ST_STALL;
    end
  end

  // Outputs follow the current cycle's selection (next_state), not the
  // registered state, so control reaches the pipeline with zero latency.
  always_comb begin
    pc_write_en    = 1'b1;
    ifid_write_en  = 1'b1;
    exmem_write_en = 1'b1;
    memwb_write_en = 1'b1;
    idex_bubble    = 1'b0;
    ifid_flush     = 1'b0;
    if (reset) begin
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      exmem_write_en = 1'b0;
      memwb_write_en = 1'b0;
      idex_bubble    = 1'b1;
    end else begin
      case (next_state)
        ST_FREEZE: begin
          pc_write_en    = 1'b0;
          ifid_write_en  = 1'b0;
          exmem_write_en = 1'b0;
          memwb_write_en = 1'b0;
        end
        ST_STALL: begin
          // Operands not ready: a taken branch must wait, so no flush here.
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_bubble   = 1'b1;
        end
        default: begin
          ifid_flush = flush_req;
        end
      endcase
    end
  end

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = (next_state == ST_STALL);
  assign flush_inc = (next_state == ST_RUN) && flush_req;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (flush_inc),
    .count (flush_cycles)
  );

  // ---------------------------------------------------------------------------
  // Watchdog: run_len counts consecutive STALL/FREEZE cycles, holding at
  // MAX_STALL; the flag is set at the edge where the run reaches MAX_STALL.
  // ---------------------------------------------------------------------------
  logic [RL_W-1:0] run_len;
  logic [RL_W-1:0] run_len_nxt;

  always_comb begin
    run_len_nxt = '0;
    if (next_state != ST_RUN) begin
      run_len_nxt = (run_len == RL_MAX) ? run_len : run_len + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_len       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      run_len <= run_len_nxt;
      if (run_len_nxt == RL_MAX) begin
        stall_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int MAX_STALL = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] id_instr;
  logic        id_branch;
  logic        id_branch_taken;
  logic        id_jump;
  logic        ex_mem_read;
  logic        ex_reg_write;
  logic [4:0]  ex_write_reg;
  logic        mem_mem_read;
  logic [4:0]  mem_write_reg;
  logic        dmem_busy;

  logic        pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
  logic        exmem_write_en, memwb_write_en, stall_timeout;
  logic [15:0] stall_cycles, flush_cycles;
  logic [1:0]  fsm_state;

  logic        s_pc, s_ifid, s_flush, s_bubble, s_exmem, s_memwb, s_timeout;
  logic [1:0]  s_stall_cycles, s_flush_cycles, s_state;

  hazard_stall_ctrl #(.CNT_W(16), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_branch(id_branch),
    .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_write_reg(ex_write_reg), .mem_mem_read(mem_mem_read),
    .mem_write_reg(mem_write_reg), .dmem_busy(dmem_busy),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_write_en(exmem_write_en), .memwb_write_en(memwb_write_en),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
    .stall_timeout(stall_timeout), .fsm_state(fsm_state)
  );

  // Narrow-counter instance, same stimulus, for saturation behaviour.
  hazard_stall_ctrl #(.CNT_W(2), .MAX_STALL(MAX_STALL)) dut_sat (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_branch(id_branch),
    .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_write_reg(ex_write_reg), .mem_mem_read(mem_mem_read),
    .mem_write_reg(mem_write_reg), .dmem_busy(dmem_busy),
    .pc_write_en(s_pc), .ifid_write_en(s_ifid),
    .ifid_flush(s_flush), .idex_bubble(s_bubble),
    .exmem_write_en(s_exmem), .memwb_write_en(s_memwb),
    .stall_cycles(s_stall_cycles), .flush_cycles(s_flush_cycles),
    .stall_timeout(s_timeout), .fsm_state(s_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int vectors    = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pipeline rules evaluated on decoded fields
  // ---------------------------------------------------------------------------
  int m_stall = 0;
  int m_flush = 0;
  int m_run   = 0;
  bit m_to    = 0;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input int r, input bit rt_counts);
    int op, src_a, src_b;
    op    = int'(ins >> 26) % 64;
    src_a = int'(ins >> 21) % 32;
    src_b = int'(ins >> 16) % 32;
    if (r == 0) return 0;
    if (r == src_a) return 1;
    if (rt_counts && (r == src_b)) return 1;
    return 0;
  endfunction

  // Expected controls for the current inputs, and the model update for the edge.
  task automatic step();
    int  op;
    bit  rt_read, hz, fl;
    int  sel;  // 0 run, 1 stall, 2 freeze
    bit  e_pc, e_ifid, e_exmem, e_memwb, e_bubble, e_flush;
    #1;
    op      = int'(id_instr >> 26) % 64;
    rt_read = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    hz = (ex_mem_read && reads_reg(id_instr, int'(ex_write_reg), rt_read)) ||
         (id_branch && ex_reg_write && reads_reg(id_instr, int'(ex_write_reg), 1)) ||
         (id_branch && mem_mem_read && reads_reg(id_instr, int'(mem_write_reg), 1));
    fl = (id_branch && id_branch_taken) || id_jump;
    sel = dmem_busy ? 2 : (hz ? 1 : 0);

    if (reset) begin
      {e_pc, e_ifid, e_exmem, e_memwb, e_bubble, e_flush} = 6'b000010;
    end else if (sel == 2) begin
      {e_pc, e_ifid, e_exmem, e_memwb, e_bubble, e_flush} = 6'b000000;
    end else if (sel == 1) begin
      {e_pc, e_ifid, e_exmem, e_memwb, e_bubble, e_flush} = 6'b001110;
    end else begin
      {e_pc, e_ifid, e_exmem, e_memwb, e_bubble, e_flush} = {4'b1111, 1'b0, fl};
    end
    check("pc_write_en",    pc_write_en,    e_pc);
    check("ifid_write_en",  ifid_write_en,  e_ifid);
    check("exmem_write_en", exmem_write_en, e_exmem);
    check("memwb_write_en", memwb_write_en, e_memwb);
    check("idex_bubble",    idex_bubble,    e_bubble);
    check("ifid_flush",     ifid_flush,     e_flush);
    check("sat_ifid_flush", s_flush,        e_flush);

    if (reset) begin
      m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
    end else begin
      if (sel == 1) m_stall++;
      if (sel == 0 && fl) m_flush++;
      m_run = (sel != 0) ? m_run + 1 : 0;
      if (m_run >= MAX_STALL) m_to = 1;
    end
    exp_q.push_back(16'(sat(m_stall, 65535)));
    exp_q.push_back(16'(sat(m_flush, 65535)));
    exp_q.push_back(16'(sat(m_stall, 3)));
    exp_q.push_back(16'(sat(m_flush, 3)));
    exp_q.push_back(16'(m_to));

    @(posedge clk);
    #1;
    check("stall_cycles",      stall_cycles,   exp_q.pop_front());
    check("flush_cycles",      flush_cycles,   exp_q.pop_front());
    check("sat_stall_cycles",  s_stall_cycles, exp_q.pop_front());
    check("sat_flush_cycles",  s_flush_cycles, exp_q.pop_front());
    check("stall_timeout",     stall_timeout,  exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [4:0] rs_f,
                                           input logic [4:0] rt_f);
    return {op, rs_f, rt_f, 16'h4820};
  endfunction

  task automatic idle_inputs();
    reset = 0; id_instr = 32'h0; id_branch = 0; id_branch_taken = 0; id_jump = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_write_reg = 0;
    mem_mem_read = 0; mem_write_reg = 0; dmem_busy = 0;
  endtask

  task automatic do_reset(input int cycles);
    idle_inputs();
    reset = 1;
    for (int i = 0; i < cycles; i++) step();
    reset = 0;
  endtask

  task automatic ex_load(input logic [4:0] r);
    ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = r;
  endtask

  logic [5:0] op_tab [8] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08, 6'h02, 6'h03};

  task automatic random_cycle();
    logic [5:0] op;
    op = op_tab[$urandom_range(0, 7)];
    reset           = ($urandom_range(0, 99) < 2);
    id_instr        = mk_instr(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    id_branch       = (op == 6'h04 || op == 6'h05) ? 1'b1 : ($urandom_range(0, 9) == 0);
    id_branch_taken = $urandom_range(0, 1);
    id_jump         = (op == 6'h02 || op == 6'h03) ? 1'b1 : ($urandom_range(0, 15) == 0);
    ex_mem_read     = $urandom_range(0, 1);
    ex_reg_write    = ex_mem_read | 1'($urandom_range(0, 1));
    ex_write_reg    = 5'($urandom_range(0, 3));
    mem_mem_read    = $urandom_range(0, 1);
    mem_write_reg   = 5'($urandom_range(0, 3));
    dmem_busy       = ($urandom_range(0, 99) < 15);
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    do_reset(2);
    check("reset_stall_cycles", stall_cycles, 16'd0);

    // Load-use: lw $2 in EX, add rs=2 in ID; then lw advances to MEM.
    id_instr = mk_instr(6'h00, 5'd2, 5'd7);
    ex_load(5'd2);
    step();
    check("load_use_count", stall_cycles, 16'd1);
    ex_mem_read = 0; ex_reg_write = 0; ex_write_reg = 0;
    mem_mem_read = 1; mem_write_reg = 5'd2;
    step();

    // Load -> beq: two stalls (EX then MEM), then taken branch flushes.
    idle_inputs();
    id_instr = mk_instr(6'h04, 5'd3, 5'd0); id_branch = 1; id_branch_taken = 1;
    ex_load(5'd3);
    step();
    ex_mem_read = 0; ex_reg_write = 0; ex_write_reg = 0;
    mem_mem_read = 1; mem_write_reg = 5'd3;
    step();
    mem_mem_read = 0; mem_write_reg = 0;
    step();
    check("branch_stall_count", stall_cycles, 16'd3);
    check("branch_flush_count", flush_cycles, 16'd1);

    // addi rt=5 against lw $5: rt is not a source, no stall.
    idle_inputs();
    id_instr = mk_instr(6'h08, 5'd1, 5'd5);
    ex_load(5'd5);
    step();
    id_instr = mk_instr(6'h00, 5'd0, 5'd0);
    ex_load(5'd0);
    step();
    check("no_stall_count", stall_cycles, 16'd3);

    // Busy during a load-use stall: 3 freeze cycles, then the stall resumes.
    idle_inputs();
    id_instr = mk_instr(6'h2B, 5'd9, 5'd4);
    ex_load(5'd4);
    dmem_busy = 1;
    for (int i = 0; i < 3; i++) step();
    dmem_busy = 0;
    step();
    check("freeze_stall_count", stall_cycles, 16'd4);
    idle_inputs();
    step();

    // Watchdog: busy for MAX_STALL cycles trips the sticky flag.
    dmem_busy = 1;
    for (int i = 0; i < MAX_STALL; i++) step();
    dmem_busy = 0;
    step();
    step();
    check("timeout_sticky", stall_timeout, 1'b1);
    do_reset(1);
    check("timeout_cleared", stall_timeout, 1'b0);
    check("flush_cleared",   flush_cycles,  16'd0);

    // Five jumps: narrow counter saturates at 3.
    id_jump = 1;
    for (int i = 0; i < 5; i++) step();
    check("flush_saturate", s_flush_cycles, 2'd3);
    check("flush_wide",     flush_cycles,   16'd5);
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) random_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Hazard detection and stall/flush controller for the 5-stage MIPS pipeline. It is the producer side of the operand-hazard path: the forwarding unit resolves EX-stage operand hazards by bypass, and this block handles the hazards that bypass cannot cover. It detects load-use hazards and branch-operand hazards for ID-resolved branches, inserts ID/EX bubbles, freezes the pipeline on data-memory wait, and flushes IF/ID on taken branches and jumps. It also keeps stall and flush statistics and runs a stall watchdog.

Parameters:
CNT_W, 16, width of the saturating stall and flush statistic counters.
MAX_STALL, 8, consecutive non-RUN cycles that trip stall_timeout.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
id_instr  in  32  instruction in ID; rs=[25:21], rt=[20:16], opcode=[31:26].
id_branch  in  1  ID holds beq/bne.
id_branch_taken  in  1  branch comparison in ID resolved taken; valid only when id_branch=1.
id_jump  in  1  ID holds j/jal/jr.
ex_mem_read  in  1  EX instruction is a load.
ex_reg_write  in  1  EX instruction writes the register file.
ex_write_reg  in  5  EX destination register.
mem_mem_read  in  1  MEM instruction is a load.
mem_write_reg  in  5  MEM destination register.
dmem_busy  in  1  data memory wait request.
pc_write_en  out  1  PC update enable.
ifid_write_en  out  1  IF/ID register enable.
ifid_flush  out  1  IF/ID register load NOP.
idex_bubble  out  1  ID/EX register load control zeros.
exmem_write_en  out  1  EX/MEM register enable.
memwb_write_en  out  1  MEM/WB register enable.
stall_cycles  out  CNT_W  saturating count of STALL cycles.
flush_cycles  out  CNT_W  saturating count of flush cycles.
stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset and synchronous clearing:
  - While reset is high, outputs are forced: pc_write_en=0, ifid_write_en=0, exmem_write_en=0, memwb_write_en=0, idex_bubble=1, ifid_flush=0.
  - At the edge where reset is sampled high: stall_cycles=0, flush_cycles=0, stall_timeout=0, run_len=0, state=RUN.
- uses_rt=1 when opcode is 0x00 (R-type), 0x04/0x05 (beq/bne) or 0x2B (sw).
- Register 0 never causes a hazard.
- Control outputs are Mealy: computed combinationally from the current inputs each cycle, with zero-cycle latency.
- The FSM (RUN, STALL, FREEZE) is the registered next state. It drives the counters and the watchdog only.
- Hazard conditions:
  - load_use = ex_mem_read & ex_write_reg!=0 & (ex_write_reg==rs | (uses_rt & ex_write_reg==rt)).
  - br_ex = id_branch & ex_reg_write & ex_write_reg!=0 & ex_write_reg∈{rs,rt}. This covers both ALU and load producers in EX.
  - br_mem = id_branch & mem_mem_read & mem_write_reg!=0 & mem_write_reg∈{rs,rt}.
  - hazard = load_use | br_ex | br_mem.
  - A branch that depends on a load in EX therefore stalls 2 cycles (br_ex, then br_mem). A branch depending on an EX ALU result stalls 1 cycle.
- Priority, highest first:
  - dmem_busy (FREEZE): all four enables=0, idex_bubble=0, ifid_flush=0. Next state FREEZE.
  - hazard (STALL): pc_write_en=0, ifid_write_en=0, idex_bubble=1, exmem_write_en=1, memwb_write_en=1, ifid_flush=0. Next state STALL.
    - A taken branch whose operands are not ready does not flush; id_branch_taken is ignored in this case.
  - (id_branch & id_branch_taken) | id_jump (flush): all enables=1, idex_bubble=0, ifid_flush=1. Next state RUN. flush_cycles increments.
  - otherwise: all enables=1, bubble=0, flush=0. Next state RUN.
- Counters and watchdog:
  - stall_cycles increments at each edge whose current cycle selects STALL. Both statistic counters saturate at 2^CNT_W-1.
  - run_len increments on each STALL/FREEZE cycle and clears on a RUN-priority cycle.
  - When run_len reaches MAX_STALL, stall_timeout sets and stays set until reset.
- dmem_busy rising during a stall: FREEZE takes over with no bubble. The stall is re-evaluated when busy drops; the inputs are unchanged, so STALL resumes.
- Reset asserted mid-stall or mid-freeze takes effect immediately, combinationally on outputs and at the next edge for state.

Decomposition:
- Shared package mips_pipe_pkg:
  - opcode constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW, OP_J, OP_JAL.
  - field slice constants.
  - state enum.
  - REG_ZERO.
- One natural sub-module, sat_counter (parameter W; inputs inc, clr; output count), instantiated twice.

Test Plan:
- lw $2 in EX (ex_mem_read=1, ex_write_reg=2), ID add rs=2 -> one cycle of pc_write_en=0, ifid_write_en=0, idex_bubble=1, stall_cycles 0->1. Next cycle, with the lw moved to MEM, normal flow.
- lw $3 in EX, ID beq rs=3 -> two consecutive stall cycles (br_ex then br_mem), stall_cycles=2, no flush. Third cycle with id_branch_taken=1 -> ifid_flush=1, flush_cycles=1.
- ID addi (opcode 0x08) rt=5, EX lw $5 -> no stall, since rt is not a use. Same with ex_write_reg=0 and rs=0 -> no stall.
- dmem_busy=1 for 3 cycles during a load-use stall -> all enables=0, bubble=0 for 3 cycles. Then the stall resumes for 1 cycle; stall_cycles counts only the STALL cycles.
- MAX_STALL=8, dmem_busy held 8 cycles -> stall_timeout=1 after the 8th edge and stays 1 after busy drops. Reset clears it and both counters.
- CNT_W=2, 5 taken jumps -> flush_cycles saturates at 3.
